// File: rtl/twin_stick_pkg.sv
// Shared definitions for the twin-stick input conditioner: nibble bit order,
// MiSTer joystick word layout and the per-stick direction struct.
package twin_stick_pkg;

  localparam int unsigned DIR_UR = 0;
  localparam int unsigned DIR_UL = 1;
  localparam int unsigned DIR_DR = 2;
  localparam int unsigned DIR_DL = 3;

  localparam int unsigned JB_RIGHT = 0;
  localparam int unsigned JB_LEFT  = 1;
  localparam int unsigned JB_DOWN  = 2;
  localparam int unsigned JB_UP    = 3;
  localparam int unsigned JB_TRIG  = 4;
  localparam int unsigned JB_START = 5;
  localparam int unsigned JB_COIN  = 6;
  localparam int unsigned JB_X     = 7;
  localparam int unsigned JB_B     = 8;
  localparam int unsigned JB_Y     = 9;
  localparam int unsigned JB_A     = 10;

  typedef struct packed {
    logic u;
    logic d;
    logic l;
    logic r;
  } axis_dirs_t;

  function automatic logic [3:0] diag_nibble(input axis_dirs_t a);
    logic [3:0] n;
    n         = '0;
    n[DIR_UR] = a.u & a.r;
    n[DIR_UL] = a.u & a.l;
    n[DIR_DR] = a.d & a.r;
    n[DIR_DL] = a.d & a.l;
    return n;
  endfunction

endpackage

// File: rtl/twin_stick_mapper_stick_filter.sv
// One analog stick: per-axis hysteresis, diagonal mapping, digital merge or
// fallback, and a tick-based stabiliser producing the output nibble.
module stick_filter
  import twin_stick_pkg::*;
#(
  parameter int   TH_ON         = 24,
  parameter int   TH_OFF        = 16,
  parameter int   STABLE_TICKS  = 3,
  parameter logic MERGE_DIGITAL = 1'b0
) (
  input  logic        clock_12,
  input  logic        reset,
  input  logic        tick,
  input  logic [15:0] analog,
  input  logic [3:0]  digital,
  output logic [3:0]  nibble
);

  localparam logic signed [7:0] ON_POS  = 8'(TH_ON);
  localparam logic signed [7:0] ON_NEG  = 8'(-TH_ON);
  localparam logic signed [7:0] OFF_POS = 8'(TH_OFF);
  localparam logic signed [7:0] OFF_NEG = 8'(-TH_OFF);
  localparam int unsigned CW = (STABLE_TICKS > 2) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 2);

  logic signed [7:0] ax, ay;
  axis_dirs_t        dirs_q, dirs_d;
  logic [3:0]        cand_d, cand_q, pend_q;
  logic [CW-1:0]     cnt_q;

  assign ax = analog[7:0];
  assign ay = analog[15:8];

  // Engage beyond TH_ON, release inside TH_OFF, hold in between.
  always_comb begin
    dirs_d = dirs_q;
    if (ay < ON_NEG)       dirs_d.u = 1'b1;
    else if (ay > OFF_NEG) dirs_d.u = 1'b0;
    if (ay > ON_POS)       dirs_d.d = 1'b1;
    else if (ay < OFF_POS) dirs_d.d = 1'b0;
    if (ax < ON_NEG)       dirs_d.l = 1'b1;
    else if (ax > OFF_NEG) dirs_d.l = 1'b0;
    if (ax > ON_POS)       dirs_d.r = 1'b1;
    else if (ax < OFF_POS) dirs_d.r = 1'b0;
  end

  always_comb begin
    cand_d = '0;
    if (MERGE_DIGITAL)
      cand_d = diag_nibble(dirs_q) | digital;
    else if (dirs_q != '0)
      cand_d = diag_nibble(dirs_q);
    else
      cand_d = digital;
  end

  // The tick that latches a new pending value is its first stable sample, so
  // the output commits on the STABLE_TICKS-th consecutive matching tick.
  always_ff @(posedge clock_12) begin
    if (reset) begin
      dirs_q <= '0;
      cand_q <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
      nibble <= '0;
    end else begin
      dirs_q <= dirs_d;
      cand_q <= cand_d;
      if (tick) begin
        if (cand_q != pend_q) begin
          pend_q <= cand_q;
          cnt_q  <= '0;
        end else if (cnt_q < CNT_LAST) begin
          cnt_q <= cnt_q + CW'(1);
        end else begin
          nibble <= pend_q;
        end
      end
    end
  end

endmodule

// File: rtl/twin_stick_mapper.sv
// Inferno input conditioner: tick prescaler, four stick filters, Aim+Fire
// trigger synthesis with release hold, and registered start/coin lines.
module twin_stick_mapper
  import twin_stick_pkg::*;
#(
  parameter int CLK_HZ          = 12000000,
  parameter int TICK_HZ         = 1000,
  parameter int TH_ON           = 24,
  parameter int TH_OFF          = 16,
  parameter int STABLE_TICKS    = 3,
  parameter int TRIG_HOLD_TICKS = 8
) (
  input  logic        clock_12,
  input  logic        reset,
  input  logic        aimfire_en,
  input  logic [31:0] joystick_0,
  input  logic [31:0] joystick_1,
  input  logic [15:0] joystick_l_analog_0,
  input  logic [15:0] joystick_l_analog_1,
  input  logic [15:0] joystick_r_analog_0,
  input  logic [15:0] joystick_r_analog_1,
  output logic [3:0]  btn_run_1,
  output logic [3:0]  btn_run_2,
  output logic [3:0]  btn_aim_1,
  output logic [3:0]  btn_aim_2,
  output logic        btn_trigger_1,
  output logic        btn_trigger_2,
  output logic        btn_start_1,
  output logic        btn_start_2,
  output logic        btn_coin
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(DIV - 1);
  localparam int unsigned HW  = $clog2(TRIG_HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(TRIG_HOLD_TICKS);

  logic [PW-1:0] pcnt_q;
  logic          tick;
  logic [10:0]   joy [2];
  logic [3:0]    run_dig [2];
  logic [3:0]    aim_dig [2];
  logic [3:0]    aim [2];
  logic [1:0]    aim_nz, aim_prev_q, aim_release, trig_q, start_q;
  logic [HW-1:0] hold_q [2];
  logic          coin_q;
  logic          unused_joy_bits;

  assign joy[0] = joystick_0[10:0];
  assign joy[1] = joystick_1[10:0];
  assign unused_joy_bits = ^{joystick_0[31:11], joystick_1[31:11]};

  assign tick = (pcnt_q == PLAST);

  always_ff @(posedge clock_12) begin
    if (reset)     pcnt_q <= '0;
    else if (tick) pcnt_q <= '0;
    else           pcnt_q <= pcnt_q + PW'(1);
  end

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      run_dig[i]         = '0;
      run_dig[i][DIR_UR] = joy[i][JB_UP];
      run_dig[i][DIR_DL] = joy[i][JB_DOWN];
      run_dig[i][DIR_UL] = joy[i][JB_LEFT];
      run_dig[i][DIR_DR] = joy[i][JB_RIGHT];
      aim_dig[i]         = '0;
      aim_dig[i][DIR_UR] = joy[i][JB_X];
      aim_dig[i][DIR_DL] = joy[i][JB_B];
      aim_dig[i][DIR_UL] = joy[i][JB_Y];
      aim_dig[i][DIR_DR] = joy[i][JB_A];
    end
  end

  stick_filter #(.TH_ON(TH_ON), .TH_OFF(TH_OFF), .STABLE_TICKS(STABLE_TICKS),
                 .MERGE_DIGITAL(1'b0)) u_run_1 (
    .clock_12(clock_12), .reset(reset), .tick(tick),
    .analog(joystick_l_analog_0), .digital(run_dig[0]), .nibble(btn_run_1));

  stick_filter #(.TH_ON(TH_ON), .TH_OFF(TH_OFF), .STABLE_TICKS(STABLE_TICKS),
                 .MERGE_DIGITAL(1'b0)) u_run_2 (
    .clock_12(clock_12), .reset(reset), .tick(tick),
    .analog(joystick_l_analog_1), .digital(run_dig[1]), .nibble(btn_run_2));

  stick_filter #(.TH_ON(TH_ON), .TH_OFF(TH_OFF), .STABLE_TICKS(STABLE_TICKS),
                 .MERGE_DIGITAL(1'b1)) u_aim_1 (
    .clock_12(clock_12), .reset(reset), .tick(tick),
    .analog(joystick_r_analog_0), .digital(aim_dig[0]), .nibble(btn_aim_1));

  stick_filter #(.TH_ON(TH_ON), .TH_OFF(TH_OFF), .STABLE_TICKS(STABLE_TICKS),
                 .MERGE_DIGITAL(1'b1)) u_aim_2 (
    .clock_12(clock_12), .reset(reset), .tick(tick),
    .analog(joystick_r_analog_1), .digital(aim_dig[1]), .nibble(btn_aim_2));

  assign aim[0] = btn_aim_1;
  assign aim[1] = btn_aim_2;

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      aim_nz[i]      = (aim[i] != '0);
      aim_release[i] = aim_prev_q[i] & ~aim_nz[i];
    end
  end

  // The release cycle itself keeps the trigger high so the hold window starts
  // without a one-clock gap.
  always_ff @(posedge clock_12) begin
    if (reset) begin
      aim_prev_q <= '0;
      trig_q     <= '0;
      start_q    <= '0;
      coin_q     <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) hold_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        aim_prev_q[i] <= aim_nz[i];
        if (!aimfire_en) begin
          hold_q[i] <= '0;
          trig_q[i] <= joy[i][JB_TRIG];
        end else begin
          if (aim_release[i])
            hold_q[i] <= HOLD_LOAD;
          else if (tick && (hold_q[i] != '0))
            hold_q[i] <= hold_q[i] - HW'(1);
          trig_q[i] <= aim_nz[i] | aim_release[i] | (hold_q[i] != '0);
        end
      end
      start_q <= {joy[1][JB_START], joy[0][JB_START]};
      coin_q  <= joy[0][JB_COIN] | joy[1][JB_COIN];
    end
  end

  assign btn_trigger_1 = trig_q[0];
  assign btn_trigger_2 = trig_q[1];
  assign btn_start_1   = start_q[0];
  assign btn_start_2   = start_q[1];
  assign btn_coin      = coin_q;

endmodule

// File: tb/tb_twin_stick_mapper.sv
// Directed self-checking bench for twin_stick_mapper with a 12-clock tick.
module tb_twin_stick_mapper;

  logic        clock_12 = 1'b0;
  logic        reset;
  logic        aimfire_en;
  logic [31:0] joystick_0, joystick_1;
  logic [15:0] joystick_l_analog_0, joystick_l_analog_1;
  logic [15:0] joystick_r_analog_0, joystick_r_analog_1;
  logic [3:0]  btn_run_1, btn_run_2, btn_aim_1, btn_aim_2;
  logic        btn_trigger_1, btn_trigger_2, btn_start_1, btn_start_2, btn_coin;

  int checks = 0;
  int errors = 0;

  twin_stick_mapper #(.CLK_HZ(12), .TICK_HZ(1), .TH_ON(24), .TH_OFF(16),
                      .STABLE_TICKS(3), .TRIG_HOLD_TICKS(8)) dut (
    .clock_12(clock_12), .reset(reset), .aimfire_en(aimfire_en),
    .joystick_0(joystick_0), .joystick_1(joystick_1),
    .joystick_l_analog_0(joystick_l_analog_0), .joystick_l_analog_1(joystick_l_analog_1),
    .joystick_r_analog_0(joystick_r_analog_0), .joystick_r_analog_1(joystick_r_analog_1),
    .btn_run_1(btn_run_1), .btn_run_2(btn_run_2),
    .btn_aim_1(btn_aim_1), .btn_aim_2(btn_aim_2),
    .btn_trigger_1(btn_trigger_1), .btn_trigger_2(btn_trigger_2),
    .btn_start_1(btn_start_1), .btn_start_2(btn_start_2), .btn_coin(btn_coin));

  always #5 clock_12 = ~clock_12;

  function automatic logic [20:0] all_outs();
    return {btn_run_1, btn_run_2, btn_aim_1, btn_aim_2, btn_trigger_1,
            btn_trigger_2, btn_start_1, btn_start_2, btn_coin};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock_12);
    #1;
  endtask

  task automatic test_reset();
    joystick_l_analog_0 = 16'h6464; joystick_l_analog_1 = 16'h6464;
    joystick_r_analog_0 = 16'h6464; joystick_r_analog_1 = 16'h6464;
    reset = 1'b1;
    step(3);
    checks++;
    if (all_outs() !== 21'h0) begin
      errors++; $display("FAIL reset_hold: got %h expected %h", all_outs(), 21'h0);
    end
    reset = 1'b0;
    step(1);
    checks++;
    if (all_outs() !== 21'h0) begin
      errors++; $display("FAIL reset_release_1clk: got %h expected %h", all_outs(), 21'h0);
    end
    step(34);
    checks++;
    if (btn_run_1 !== 4'b0000) begin
      errors++; $display("FAIL reset_before_3rd_tick: got %b expected %b", btn_run_1, 4'b0000);
    end
    step(1);
    checks++;
    if ({btn_run_1, btn_run_2, btn_aim_1, btn_aim_2} !== 16'h4444) begin
      errors++; $display("FAIL reset_after_3_ticks: got %h expected %h",
                         {btn_run_1, btn_run_2, btn_aim_1, btn_aim_2}, 16'h4444);
    end
  endtask

  task automatic test_hysteresis();
    joystick_l_analog_0 = 16'h0000;
    step(48);
    checks++;
    if (btn_run_1 !== 4'b0000) begin
      errors++; $display("FAIL hyst_rest: got %b expected %b", btn_run_1, 4'b0000);
    end
    for (int v = 0; v <= 25; v += 5) begin
      joystick_l_analog_0 = {8'(-v), 8'(v)};
      step(1);
    end
    step(48);
    checks++;
    if (btn_run_1 !== 4'b0001) begin
      errors++; $display("FAIL hyst_engage_ur: got %b expected %b", btn_run_1, 4'b0001);
    end
    joystick_l_analog_0 = {8'(-17), 8'd25};
    step(48);
    checks++;
    if (btn_run_1 !== 4'b0001) begin
      errors++; $display("FAIL hyst_hold_m17: got %b expected %b", btn_run_1, 4'b0001);
    end
    joystick_l_analog_0 = {8'(-15), 8'd25};
    step(24);
    checks++;
    if (btn_run_1 !== 4'b0001) begin
      errors++; $display("FAIL hyst_release_early: got %b expected %b", btn_run_1, 4'b0001);
    end
    step(24);
    checks++;
    if (btn_run_1 !== 4'b0000) begin
      errors++; $display("FAIL hyst_release_m15: got %b expected %b", btn_run_1, 4'b0000);
    end
    joystick_l_analog_0 = {8'(-20), 8'd25};
    step(48);
    checks++;
    if (btn_run_1 !== 4'b0000) begin
      errors++; $display("FAIL hyst_no_engage_m20: got %b expected %b", btn_run_1, 4'b0000);
    end
    joystick_l_analog_0 = {8'h80, 8'h00};
    step(48);
    checks++;
    if (btn_run_1 !== 4'b0000) begin
      errors++; $display("FAIL hyst_m128_cardinal: got %b expected %b", btn_run_1, 4'b0000);
    end
    joystick_l_analog_0 = 16'h8080;
    step(48);
    checks++;
    if (btn_run_1 !== 4'b0010) begin
      errors++; $display("FAIL hyst_m128_ul: got %b expected %b", btn_run_1, 4'b0010);
    end
  endtask

  task automatic test_digital_fallback();
    joystick_l_analog_0 = 16'h0000;
    joystick_0 = 32'h0000_0004;
    step(48);
    checks++;
    if (btn_run_1 !== 4'b1000) begin
      errors++; $display("FAIL dpad_down: got %b expected %b", btn_run_1, 4'b1000);
    end
    joystick_l_analog_0 = {8'd30, 8'd30};
    step(48);
    checks++;
    if (btn_run_1 !== 4'b0100) begin
      errors++; $display("FAIL analog_wins: got %b expected %b", btn_run_1, 4'b0100);
    end
    joystick_l_analog_0 = 16'h0000;
    joystick_0 = 32'h0000_0002;
    step(48);
    checks++;
    if (btn_run_1 !== 4'b0010) begin
      errors++; $display("FAIL dpad_left: got %b expected %b", btn_run_1, 4'b0010);
    end
    joystick_0 = '0;
    step(48);
  endtask

  task automatic test_glitch();
    logic [3:0] seen;
    seen = btn_aim_1;
    joystick_0 = 32'h0000_0200;
    for (int i = 0; i < 12; i++) begin step(1); seen |= btn_aim_1; end
    joystick_0 = '0;
    for (int i = 0; i < 60; i++) begin step(1); seen |= btn_aim_1; end
    checks++;
    if (seen !== 4'b0000) begin
      errors++; $display("FAIL glitch_rejected: got %b expected %b", seen, 4'b0000);
    end
    joystick_0 = 32'h0000_0200;
    step(48);
    checks++;
    if (btn_aim_1 !== 4'b0010) begin
      errors++; $display("FAIL glitch_held: got %b expected %b", btn_aim_1, 4'b0010);
    end
    joystick_0 = '0;
    step(48);
  endtask

  task automatic test_aimfire();
    int n;
    aimfire_en = 1'b1;
    step(2);
    checks++;
    if (btn_trigger_2 !== 1'b0) begin
      errors++; $display("FAIL af_idle: got %b expected %b", btn_trigger_2, 1'b0);
    end
    joystick_1 = 32'h0000_0200;
    step(48);
    checks++;
    if ({btn_aim_2, btn_trigger_2} !== 5'b0010_1) begin
      errors++; $display("FAIL af_aim_trigger: got %b expected %b", {btn_aim_2, btn_trigger_2}, 5'b0010_1);
    end
    joystick_1 = '0;
    n = 0;
    while (btn_aim_2 !== 4'b0000 && n < 60) begin step(1); n++; end
    checks++;
    if (n >= 60) begin
      errors++; $display("FAIL af_release_timeout: got %0d expected <60", n);
    end
    n = 0;
    while (btn_trigger_2 === 1'b1 && n < 200) begin n++; step(1); end
    checks++;
    if (n !== 97) begin
      errors++; $display("FAIL af_hold_len: got %0d clocks expected %0d", n, 97);
    end
    joystick_1 = 32'h0000_0200;
    step(48);
    joystick_1 = '0;
    n = 0;
    while (btn_aim_2 !== 4'b0000 && n < 60) begin step(1); n++; end
    step(20);
    checks++;
    if (btn_trigger_2 !== 1'b1) begin
      errors++; $display("FAIL af_mid_hold: got %b expected %b", btn_trigger_2, 1'b1);
    end
    aimfire_en = 1'b0;
    step(1);
    checks++;
    if (btn_trigger_2 !== 1'b0) begin
      errors++; $display("FAIL af_disable_mid_hold: got %b expected %b", btn_trigger_2, 1'b0);
    end
  endtask

  task automatic test_passthrough();
    joystick_1 = 32'h0000_0010;
    #1;
    checks++;
    if (btn_trigger_2 !== 1'b0) begin
      errors++; $display("FAIL trig_not_early: got %b expected %b", btn_trigger_2, 1'b0);
    end
    step(1);
    checks++;
    if ({btn_trigger_1, btn_trigger_2} !== 2'b01) begin
      errors++; $display("FAIL trig_pass: got %b expected %b", {btn_trigger_1, btn_trigger_2}, 2'b01);
    end
    joystick_1 = '0;
    step(1);
    checks++;
    if (btn_trigger_2 !== 1'b0) begin
      errors++; $display("FAIL trig_pass_release: got %b expected %b", btn_trigger_2, 1'b0);
    end
  endtask

  task automatic test_coin_start();
    joystick_1 = 32'h0000_0040;
    #1;
    checks++;
    if (btn_coin !== 1'b0) begin
      errors++; $display("FAIL coin_not_early: got %b expected %b", btn_coin, 1'b0);
    end
    step(1);
    checks++;
    if (btn_coin !== 1'b1) begin
      errors++; $display("FAIL coin_next_clk: got %b expected %b", btn_coin, 1'b1);
    end
    joystick_1 = '0;
    joystick_0 = 32'h0000_0020;
    step(1);
    checks++;
    if ({btn_start_1, btn_start_2, btn_coin} !== 3'b100) begin
      errors++; $display("FAIL start_1: got %b expected %b", {btn_start_1, btn_start_2, btn_coin}, 3'b100);
    end
    joystick_0 = '0;
    step(1);
  endtask

  task automatic test_reset_midop();
    joystick_l_analog_0 = 16'h6464;
    joystick_0 = 32'h0000_0030;
    joystick_1 = 32'h0000_0040;
    step(48);
    checks++;
    if ({btn_run_1, btn_trigger_1, btn_start_1, btn_coin} !== 7'b0100_111) begin
      errors++; $display("FAIL midop_active: got %b expected %b",
                         {btn_run_1, btn_trigger_1, btn_start_1, btn_coin}, 7'b0100_111);
    end
    reset = 1'b1;
    step(1);
    checks++;
    if (all_outs() !== 21'h0) begin
      errors++; $display("FAIL midop_reset: got %h expected %h", all_outs(), 21'h0);
    end
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; aimfire_en = 1'b0;
    joystick_0 = '0; joystick_1 = '0;
    joystick_l_analog_0 = '0; joystick_l_analog_1 = '0;
    joystick_r_analog_0 = '0; joystick_r_analog_1 = '0;
    @(posedge clock_12); #1;
    test_reset();
    joystick_l_analog_1 = '0; joystick_r_analog_0 = '0; joystick_r_analog_1 = '0;
    test_hysteresis();
    test_digital_fallback();
    test_glitch();
    test_aimfire();
    test_passthrough();
    test_coin_start();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
